// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run-control block: operator modes and FSM states.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_STEP_CYC = 2'b01,
        MODE_STEP_INS = 2'b10,
        MODE_HALT     = 2'b11
    } mode_e;

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_INS  = 2'd3;

    // Every state except S_HALT lets the CPU advance.
    function automatic logic state_enables_cpu(input logic [1:0] s);
        return s != S_HALT;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-side signal bundle of cpu_run_ctrl: buttons, mode switches, CPU status in, enables/counters out.
interface cpu_run_ctrl_if #(
    parameter int BTN_N = 2,
    parameter int CNT_W = 8,
    parameter int PC_W  = 32
);
    logic [BTN_N-1:0] btn_raw;
    logic [1:0]       mode;
    logic             instr_done;
    logic [PC_W-1:0]  pc;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [BTN_N-1:0] btn_db;
    logic [BTN_N-1:0] btn_rise;
    logic             cpu_ce;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport slave (
        input  btn_raw, mode, instr_done, pc, bp_en, bp_addr,
        output btn_db, btn_rise, cpu_ce, halted, bp_hit, cycle_cnt, instr_cnt
    );

    modport master (
        output btn_raw, mode, instr_done, pc, bp_en, bp_addr,
        input  btn_db, btn_rise, cpu_ce, halted, bp_hit, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl_db_chan.sv
// One push-button debounce channel: two-flop synchroniser, stability counter,
// debounced level and a registered one-cycle pulse on each accepted 0->1 change.
module db_chan #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    logic            sync1_reg;
    logic            sync2_reg;
    logic [DB_W-1:0] cnt_reg;
    logic            level_reg;
    logic            rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (&cnt_reg) begin
                // Input held the new value for 2^DB_W cycles: accept it.
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
                rise_reg  <= ~level_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the multi-cycle CPU: debounced buttons, clock-enable FSM, counters.
// Optional PC breakpoint comparator is built when CPU_RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int BTN_N = 2,
    parameter int DB_W  = 16,
    parameter int CNT_W = 8,
    parameter int PC_W  = 32
) (
    input logic           clk,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus
);
    logic [BTN_N-1:0] btn_db_w;
    logic [BTN_N-1:0] btn_rise_w;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_N; gi++) begin : g_db
            db_chan #(.DB_W(DB_W)) u_db_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (bus.btn_raw[gi]),
                .level (btn_db_w[gi]),
                .rise  (btn_rise_w[gi])
            );
        end
    endgenerate

    logic [1:0]       state_reg, state_next;
    logic             cpu_ce_reg;
    logic             bp_hit_reg, bp_hit_next;
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_reg;
    logic [PC_W-1:0]  pc_in;
    logic [PC_W-1:0]  bp_addr_in;
    logic             bp_match;
    mode_e            mode_in;

    assign pc_in      = bus.pc;
    assign bp_addr_in = bus.bp_addr;
    assign mode_in    = mode_e'(bus.mode);

`ifdef CPU_RUN_CTRL_BP_EN
    // The next fetch address is on pc during instr_done, so halting here keeps it unfetched.
    assign bp_match = bus.bp_en && bus.instr_done && (pc_in == bp_addr_in);
`else
    logic unused_bp;
    assign unused_bp = ^{bus.bp_en, pc_in, bp_addr_in};
    assign bp_match  = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        bp_hit_next = bp_hit_reg;
        case (state_reg)
            S_HALT: begin
                if (btn_rise_w[0]) begin
                    case (mode_in)
                        MODE_RUN: begin
                            state_next  = S_RUN;
                            bp_hit_next = 1'b0;
                        end
                        MODE_STEP_CYC: state_next = S_STEP;
                        MODE_STEP_INS: state_next = S_INS;
                        default:       state_next = S_HALT;
                    endcase
                end
            end
            S_STEP: state_next = S_HALT;
            S_INS: begin
                if (bus.instr_done) state_next = S_HALT;
            end
            S_RUN: begin
                if (bp_match) begin
                    state_next  = S_HALT;
                    bp_hit_next = 1'b1;
                end else if (mode_in != MODE_RUN) begin
                    state_next = S_HALT;
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_HALT;
            cpu_ce_reg    <= 1'b0;
            bp_hit_reg    <= 1'b0;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cpu_ce_reg <= state_enables_cpu(state_next);
            bp_hit_reg <= bp_hit_next;
            if (cpu_ce_reg) begin
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
                if (bus.instr_done) instr_cnt_reg <= instr_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.btn_db    = btn_db_w;
    assign bus.btn_rise  = btn_rise_w;
    assign bus.cpu_ce    = cpu_ce_reg;
    assign bus.halted    = (state_reg == S_HALT);
    assign bus.bp_hit    = bp_hit_reg;
    assign bus.cycle_cnt = cycle_cnt_reg;
    assign bus.instr_cnt = instr_cnt_reg;
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run-control block for the multi-cycle CPU board top.
- Replaces the raw button-debounce and clock-mux scheme with a single-clock clock-enable generator. No gated or muxed clocks.
- Supports free-run, single-cycle step, single-instruction step, halt and PC breakpoint.
- Debounces BTN_N push-buttons and maintains cycle and instruction counters for the seven-segment displays.

Parameters:
- BTN_N, 2: number of debounced button channels. Channel 0 is the step button.
- DB_W, 16: debounce counter width. An input must be stable for 2^DB_W clk cycles before it is accepted.
- CNT_W, 8: width of cycle_cnt and instr_cnt.
- PC_W, 32: width of the pc and bp_addr compare.

Ports:
- clk, in, 1: board clock; the only clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- btn_raw, in, BTN_N: raw push-button inputs, asynchronous to clk.
- mode, in, 2: 00 RUN, 01 STEP_CYC, 10 STEP_INS, 11 HALT.
- instr_done, in, 1: from the CPU controller; high in the last cycle of an instruction (next state is fetch).
- pc, in, PC_W: address the CPU fetches after instr_done.
- bp_en, in, 1: breakpoint enable.
- bp_addr, in, PC_W: breakpoint address.
- btn_db, out, BTN_N: debounced button levels.
- btn_rise, out, BTN_N: one-cycle pulse on each debounced 0->1 edge.
- cpu_ce, out, 1: clock enable for every CPU register.
- halted, out, 1: high when the FSM is in S_HALT.
- bp_hit, out, 1: sticky breakpoint flag.
- cycle_cnt, out, CNT_W: count of enabled CPU cycles.
- instr_cnt, out, CNT_W: count of retired instructions.

Behaviour:
- Reset values (asynchronous):
  - btn_db=0, btn_rise=0, debounce counters=0.
  - FSM=S_HALT, cpu_ce=0, halted=1, bp_hit=0.
  - cycle_cnt=0, instr_cnt=0.
- Debounce, per channel:
  - Two-flop synchroniser.
  - Counter clears whenever the synchronised input equals btn_db.
  - Otherwise the counter increments. On reaching all-ones, btn_db flips and the counter clears.
  - btn_rise is registered; it is high for exactly one cycle after a 0->1 flip.
  - Input-to-btn_db latency: 2 + 2^DB_W cycles.
- FSM states: S_HALT, S_RUN, S_STEP, S_INS. cpu_ce is high in S_RUN, S_STEP and S_INS, and registered.
- S_HALT transitions:
  - mode=RUN and btn_rise[0] -> S_RUN; bp_hit clears.
  - mode=STEP_CYC and btn_rise[0] -> S_STEP.
  - mode=STEP_INS and btn_rise[0] -> S_INS.
  - mode=HALT: stay.
- S_STEP: exactly one cycle with cpu_ce=1, then S_HALT unconditionally.
- S_INS: stays while instr_done=0. Cycle with instr_done=1 -> S_HALT. At least one enabled cycle is guaranteed.
- S_RUN transitions:
  - mode=HALT -> S_HALT in the next cycle. Any instruction in flight is frozen mid-state, which is legal.
  - bp_en, instr_done and pc==bp_addr all high in one cycle -> S_HALT, bp_hit<=1. The instruction at bp_addr is not fetched.
  - mode changes to a STEP mode while running -> S_HALT.
- Breakpoints are evaluated only in S_RUN, never in S_STEP or S_INS, so stepping off a breakpoint works.
- Counters:
  - cycle_cnt increments on every cycle with cpu_ce=1.
  - instr_cnt increments on every cycle with cpu_ce=1 and instr_done=1.
  - Both wrap modulo 2^CNT_W without a flag.
- Step presses:
  - A btn_rise[0] arriving while not in S_HALT is ignored, not queued.
  - btn_rise[1..BTN_N-1] do not affect the FSM. They are exported for use as the CPU reset source.
- Asserting rst_n low mid-step aborts immediately to the reset values.

Optional Feature:
- CPU_RUN_CTRL_BP_EN:
  - Defined: the PC comparator and bp_hit are implemented as above.
  - Undefined: the comparator is removed, bp_en and bp_addr are ignored, bp_hit is tied to 0, and S_RUN exits only via mode.

Decomposition:
- Package cpu_run_ctrl_pkg:
  - mode encodings MODE_RUN, MODE_STEP_CYC, MODE_STEP_INS, MODE_HALT.
  - state encodings S_HALT, S_RUN, S_STEP, S_INS.
- Sub-module db_chan: one debounce channel (synchroniser, counter, level, rise pulse), instantiated BTN_N times by a generate loop.

Test Plan:
- Reset, then hold btn_raw[0]=1 for 2^DB_W+3 cycles -> btn_db[0]=1 and btn_rise[0] pulses exactly once. A 10-cycle glitch -> no change (bench uses DB_W=4).
- mode=01, one press -> cpu_ce high for exactly 1 cycle, cycle_cnt 0->1, halted returns to 1. Five presses -> cycle_cnt=5.
- mode=10, CPU model with instr_done every 4th enabled cycle, one press -> cpu_ce high for 4 cycles, instr_cnt=1, cycle_cnt=4.
- mode=00, bp_en=1, bp_addr=0x0000_000C, pc stepping 0,4,8,C at each instr_done -> halted with bp_hit=1 and instr_cnt=3. Switch to mode=01 and press -> CPU advances, bp_hit stays 1 until the next RUN entry.
- In S_RUN with CNT_W=8, run 260 enabled cycles -> cycle_cnt wraps to 4. Pulse rst_n low mid-run -> cpu_ce=0, counters=0, halted=1 immediately.
- Compile without CPU_RUN_CTRL_BP_EN and repeat the breakpoint scenario -> no halt, bp_hit stays 0.
